// File: rtl/irq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// irq_ctrl_pkg
// Shared constants and types for the interrupt controller.
//   - register offsets inside the 64-byte bus window
//   - claim/complete ID width, priority width, and the "no source" ID
//   - decoded register selector used by the top level
// Optional feature macro: IRQ_CTRL_PRIORITY_EN (adds THRESHOLD and PRIO regs).
// -----------------------------------------------------------------------------
package irq_ctrl_pkg;

    localparam int ID_W   = 5;  // holds index+1 for up to 31 sources
    localparam int PRIO_W = 3;

    localparam logic [ID_W-1:0] ID_NONE = '0;

    localparam logic [5:0] OFF_PENDING   = 6'h00;
    localparam logic [5:0] OFF_ENABLE    = 6'h04;
    localparam logic [5:0] OFF_CLAIM     = 6'h08;
    localparam logic [5:0] OFF_COMPLETE  = 6'h0C;
    localparam logic [5:0] OFF_THRESHOLD = 6'h10;
    localparam logic [5:0] OFF_PRIO_BASE = 6'h20;

    typedef enum logic [2:0] {
        REG_PENDING,
        REG_ENABLE,
        REG_CLAIM,
        REG_COMPLETE,
        REG_THRESHOLD,
        REG_PRIO,
        REG_NONE
    } reg_sel_e;

endpackage

// File: rtl/irq_ctrl_sync.sv
// -----------------------------------------------------------------------------
// irq_sync_edge
// Two-flop synchroniser for one asynchronous interrupt line followed by a
// rising-edge detector. rise_o is a one-pclk pulse, two clocks after the
// input is first sampled high.
// Ports:
//   pclk    in   clock
//   presetn in   asynchronous active-low reset
//   irq_i   in   asynchronous interrupt line
//   rise_o  out  single-cycle rising-edge pulse (pclk domain)
// -----------------------------------------------------------------------------
module irq_sync_edge (
    input  logic pclk,
    input  logic presetn,
    input  logic irq_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each stage take the value
            // its predecessor held before the edge, giving a real shift chain.
            meta_q <= irq_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
// Interrupt controller behind the machine timer. Source 0 is the timer's
// level interrupt; sources 1..NUM_SRC-1 are asynchronous rising-edge lines.
// Sources are latched into PENDING, masked by ENABLE and IN_SERVICE, and the
// lowest index wins a CLAIM. A registered cpu_irq goes to the core.
// Optional feature macro: IRQ_CTRL_PRIORITY_EN adds THRESHOLD (0x10) and
// PRIO[i] (0x20+4*i) registers; without it those offsets return perr=1.
// Ports:
//   pclk, presetn         clock, asynchronous active-low reset
//   paddr, pdata, pstb    APB-style address, write data, byte strobes
//   psel, penable, pwrite APB-style control
//   prdata, pready, perr  read data, one-cycle completion pulse, error
//   timer_irq             level interrupt from the timer (pclk domain)
//   ext_irq[NUM_SRC-1:1]  asynchronous external lines, bit i drives source i
//   cpu_irq               level interrupt request to the core
// -----------------------------------------------------------------------------
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_SRC    = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'('h1100_8000)
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pdata,
    output logic [DATA_WIDTH-1:0] prdata,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [3:0]            pstb,
    output logic                  pready,
    output logic                  perr,
    input  logic                  timer_irq,
    input  logic [NUM_SRC-1:1]    ext_irq,
    output logic                  cpu_irq
);

    // ---------------------------------------------------------------- state
    logic                  pready_q;
    logic                  perr_q;
    logic [DATA_WIDTH-1:0] prdata_q;
    logic                  cpu_irq_q;
    logic [NUM_SRC-1:0]    pending_q, pending_d;
    logic [NUM_SRC-1:0]    enable_q, enable_d;
    logic [NUM_SRC-1:0]    in_service_q, in_service_d;
`ifdef IRQ_CTRL_PRIORITY_EN
    logic [PRIO_W-1:0]     threshold_q, threshold_d;
    logic [PRIO_W-1:0]     prio_q [NUM_SRC];
    logic [PRIO_W-1:0]     prio_d [NUM_SRC];
    logic [2:0]            prio_sel;
    logic [PRIO_W-1:0]     best_prio;
    logic [NUM_SRC-1:0]    eligible;
`endif

    // ------------------------------------------------------ external edges
    logic [NUM_SRC-1:1] ext_rise;

    for (genvar s = 1; s < NUM_SRC; s++) begin : g_src
        irq_sync_edge u_sync (
            .pclk    (pclk),
            .presetn (presetn),
            .irq_i   (ext_irq[s]),
            .rise_o  (ext_rise[s])
        );
    end

    // ------------------------------------------------------------- decode
    logic       in_window;
    logic [5:0] off;
    reg_sel_e   reg_sel;
    logic       accept;
    logic       bus_err;
    logic       rd_en;
    logic       wr_en;

    // BASE_ADDR is 64-byte aligned, so the window is a match on the upper bits.
    assign in_window = (paddr[ADDR_WIDTH-1:6] == BASE_ADDR[ADDR_WIDTH-1:6]);
    assign off       = paddr[5:0];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        reg_sel = REG_NONE;
`ifdef IRQ_CTRL_PRIORITY_EN
        prio_sel = '0;
`endif
        if (in_window) begin
            case (off)
                OFF_PENDING:   reg_sel = REG_PENDING;
                OFF_ENABLE:    reg_sel = REG_ENABLE;
                OFF_CLAIM:     reg_sel = REG_CLAIM;
                OFF_COMPLETE:  reg_sel = REG_COMPLETE;
`ifdef IRQ_CTRL_PRIORITY_EN
                OFF_THRESHOLD: reg_sel = REG_THRESHOLD;
`endif
                default: begin
`ifdef IRQ_CTRL_PRIORITY_EN
                    // PRIO[i] lives at OFF_PRIO_BASE + 4*i; only slots that
                    // map to a real source decode.
                    if (off[5] && (off[1:0] == 2'b00) && (int'(off[4:2]) < NUM_SRC)) begin
                        reg_sel  = REG_PRIO;
                        prio_sel = off[4:2];
                    end
`endif
                end
            endcase
        end
    end

    // An access is taken once; pready_q blocks a second acceptance while
    // psel/penable are still held high.
    assign accept  = psel & penable & ~pready_q;
    assign bus_err = (reg_sel == REG_NONE);
    assign rd_en   = accept & ~pwrite & ~bus_err;
    assign wr_en   = accept &  pwrite & ~bus_err;

    // ------------------------------------------------------ claim selection
    logic [NUM_SRC-1:0] cand;
    logic               claim_found;
    logic [ID_W-1:0]    claim_idx;
    logic [ID_W-1:0]    claim_id;
    logic [ID_W-1:0]    cmp_id;

`ifdef IRQ_CTRL_PRIORITY_EN
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i] = (prio_q[i] > threshold_q);
        end
    end
    assign cand = pending_q & enable_q & ~in_service_q & eligible;
`else
    assign cand = pending_q & enable_q & ~in_service_q;
`endif

    // Ascending scan: the first candidate is kept unless a later one has a
    // strictly higher priority, so ties go to the lowest index.
    always_comb begin
        claim_found = 1'b0;
        claim_idx   = '0;
`ifdef IRQ_CTRL_PRIORITY_EN
        best_prio   = '0;
`endif
        for (int i = 0; i < NUM_SRC; i++) begin
`ifdef IRQ_CTRL_PRIORITY_EN
            if (cand[i] && (!claim_found || (prio_q[i] > best_prio))) begin
                best_prio   = prio_q[i];
`else
            if (cand[i] && !claim_found) begin
`endif
                claim_found = 1'b1;
                claim_idx   = ID_W'(i);
            end
        end
    end

    assign claim_id = claim_found ? (claim_idx + ID_W'(1)) : ID_NONE;
    assign cmp_id   = pdata[ID_W-1:0];

    // ------------------------------------------------------------ read mux
    logic [DATA_WIDTH-1:0] rdata;

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_PENDING:   rdata = DATA_WIDTH'(pending_q);
            REG_ENABLE:    rdata = DATA_WIDTH'(enable_q);
            REG_CLAIM:     rdata = DATA_WIDTH'(claim_id);
`ifdef IRQ_CTRL_PRIORITY_EN
            REG_THRESHOLD: rdata = DATA_WIDTH'(threshold_q);
            REG_PRIO: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (int'(prio_sel) == i) rdata = DATA_WIDTH'(prio_q[i]);
                end
            end
`endif
            default:       rdata = '0;
        endcase
    end

    // ---------------------------------------------------------- next state
    always_comb begin
        pending_d    = pending_q;
        enable_d     = enable_q;
        in_service_d = in_service_q;
`ifdef IRQ_CTRL_PRIORITY_EN
        threshold_d  = threshold_q;
        prio_d       = prio_q;
`endif

        // The timer is a level source: it stays pending while its line is
        // high, so claiming it only marks it in service.
        if (rd_en && (reg_sel == REG_CLAIM) && claim_found) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (claim_idx == ID_W'(i)) begin
                    in_service_d[i] = 1'b1;
                    if (i != 0) pending_d[i] = 1'b0;
                end
            end
        end

        if (wr_en) begin
            case (reg_sel)
                REG_ENABLE: begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (pstb[i/8]) enable_d[i] = pdata[i];
                    end
                end
                REG_COMPLETE: begin
                    // IDs outside 1..NUM_SRC match nothing and are ignored.
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (cmp_id == ID_W'(i + 1)) in_service_d[i] = 1'b0;
                    end
                end
`ifdef IRQ_CTRL_PRIORITY_EN
                REG_THRESHOLD: begin
                    if (pstb[0]) threshold_d = pdata[PRIO_W-1:0];
                end
                REG_PRIO: begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (pstb[0] && (int'(prio_sel) == i)) prio_d[i] = pdata[PRIO_W-1:0];
                    end
                end
`endif
                default: ;
            endcase
        end

        // Applied after the claim clear so a new edge in the claim cycle wins.
        pending_d[0]           = timer_irq;
        pending_d[NUM_SRC-1:1] = pending_d[NUM_SRC-1:1] | ext_rise;
    end

    // ----------------------------------------------------------- registers
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pready_q     <= 1'b0;
            perr_q       <= 1'b0;
            prdata_q     <= '0;
            cpu_irq_q    <= 1'b0;
            pending_q    <= '0;
            enable_q     <= '0;
            in_service_q <= '0;
`ifdef IRQ_CTRL_PRIORITY_EN
            threshold_q  <= '0;
            // NOTE: this array is a handful of control flops, not a RAM, so
            // resetting it costs nothing and gives software a known state.
            prio_q       <= '{default: '0};
`endif
        end else begin
            pready_q     <= accept;
            perr_q       <= accept & bus_err;
            prdata_q     <= rd_en ? rdata : '0;
            cpu_irq_q    <= |cand;
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            in_service_q <= in_service_d;
`ifdef IRQ_CTRL_PRIORITY_EN
            threshold_q  <= threshold_d;
            prio_q       <= prio_d;
`endif
        end
    end

    assign pready  = pready_q;
    assign perr    = perr_q;
    assign prdata  = prdata_q;
    assign cpu_irq = cpu_irq_q;

    // Data and strobe bits beyond the implemented registers are don't-care.
    logic unused_bits;
    assign unused_bits = &{1'b0, pdata, pstb};

endmodule

// File: tb/tb_irq_ctrl.sv
`timescale 1ns/1ps
module tb_irq_ctrl;

    localparam int          NS   = 8;
    localparam logic [31:0] BASE = 32'h1100_8000;

    logic          pclk = 1'b0;
    logic          presetn;
    logic [31:0]   paddr;
    logic [31:0]   pdata;
    logic [31:0]   prdata;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [3:0]    pstb;
    logic          pready;
    logic          perr;
    logic          timer_irq;
    logic [NS-1:1] ext_irq;
    logic          cpu_irq;

    always #5 pclk = ~pclk;

    irq_ctrl #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_SRC    (NS),
        .BASE_ADDR  (BASE)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .paddr     (paddr),
        .pdata     (pdata),
        .prdata    (prdata),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pstb      (pstb),
        .pready    (pready),
        .perr      (perr),
        .timer_irq (timer_irq),
        .ext_irq   (ext_irq),
        .cpu_irq   (cpu_irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: what the controller must present after each edge.
    // External lines are seen through a sample history; a rise that
    // appeared two samples ago becomes pending on this edge.
    // ------------------------------------------------------------------
    logic [NS-1:0] m_pend, m_en, m_isr;
    logic          m_pready, m_perr, m_cpu;
    logic [31:0]   m_prdata;
    logic [NS-1:1] m_hist [3];

    always @(posedge pclk) begin : model
        logic [NS-1:0] live, pend_n, en_n, isr_n;
        logic [NS-1:1] rise;
        logic          acc, good;
        int            claim, id;
        if (!presetn) begin
            m_pend = '0; m_en = '0; m_isr = '0;
            m_pready = 0; m_perr = 0; m_cpu = 0; m_prdata = '0;
            for (int k = 0; k < 3; k++) m_hist[k] = '0;
        end else begin
            live  = m_pend & m_en & ~m_isr;
            claim = 0;
            for (int i = NS - 1; i >= 0; i--) if (live[i]) claim = i + 1;
            rise   = m_hist[1] & ~m_hist[2];
            pend_n = m_pend; en_n = m_en; isr_n = m_isr;
            acc    = psel && penable && !m_pready;
            good   = (paddr[31:6] == BASE[31:6]) && (paddr[5:0] inside {6'h00, 6'h04, 6'h08, 6'h0C});
            m_perr   = acc && !good;
            m_prdata = '0;
            if (acc && good && !pwrite) begin
                case (paddr[5:0])
                    6'h00: m_prdata = 32'(m_pend);
                    6'h04: m_prdata = 32'(m_en);
                    6'h08: begin
                        m_prdata = claim;
                        if (claim != 0) begin
                            isr_n[claim-1] = 1'b1;
                            if (claim > 1) pend_n[claim-1] = 1'b0;
                        end
                    end
                    default: m_prdata = '0;
                endcase
            end else if (acc && good && pwrite) begin
                if (paddr[5:0] == 6'h04 && pstb[0]) en_n = pdata[NS-1:0];
                if (paddr[5:0] == 6'h0C) begin
                    id = int'(pdata[4:0]);
                    if (id >= 1 && id <= NS) isr_n[id-1] = 1'b0;
                end
            end
            pend_n[0]      = timer_irq;
            pend_n[NS-1:1] = pend_n[NS-1:1] | rise;
            m_cpu    = |live;
            m_pready = acc;
            m_pend = pend_n; m_en = en_n; m_isr = isr_n;
            m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = ext_irq;
        end
        #1;
        check("cpu_irq", cpu_irq, m_cpu);
        check("pready", pready, m_pready);
        if (m_pready) begin
            check("perr", perr, m_perr);
            check("prdata", prdata, m_prdata);
        end
    end

    // ------------------------------------------------------------ bus tasks
    task automatic bus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, output logic [31:0] rd, output logic err);
        int n;
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pdata = data; pstb = strb;
        @(negedge pclk);
        penable = 1'b1;
        n = 0;
        do begin
            @(posedge pclk); #1; n++;
        end while (!pready && n < 8);
        if (!pready) check("pready_timeout", pready, 1);
        rd  = prdata;
        err = perr;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd; logic err;
        bus(1'b0, addr, 32'h0, 4'h0, rd, err);
        check(name, rd, exp);
        check({name, "_perr"}, err, 0);
    endtask

    task automatic wr_chk(input string name, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic exp_err);
        logic [31:0] rd; logic err;
        bus(1'b1, addr, data, strb, rd, err);
        check({name, "_perr"}, err, exp_err);
    endtask

    // --------------------------------------------------------------- stimulus
    initial begin : stim
        logic [31:0] rd; logic err;
        presetn = 1'b0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pdata = '0;
        pstb = '0; timer_irq = 0; ext_irq = '0;
        repeat (3) @(negedge pclk);
        presetn = 1'b1;

        // Reset state
        rd_chk("rst_pending", BASE + 32'h00, 32'h0);
        rd_chk("rst_enable",  BASE + 32'h04, 32'h0);
        rd_chk("rst_claim",   BASE + 32'h08, 32'h0);
        check("rst_cpu_irq", cpu_irq, 0);

        // Source 2: four-clock latency, claim, complete
        wr_chk("en_04", BASE + 32'h04, 32'h04, 4'hF, 0);
        @(negedge pclk); ext_irq[2] = 1'b1;
        repeat (3) @(posedge pclk); #1 check("lat3_cpu_irq", cpu_irq, 0);
        @(posedge pclk); #1 check("lat4_cpu_irq", cpu_irq, 1);
        rd_chk("src2_pending", BASE + 32'h00, 32'h04);
        rd_chk("src2_claim",   BASE + 32'h08, 32'h3);
        @(posedge pclk); #1 check("src2_claimed_cpu_irq", cpu_irq, 0);
        rd_chk("src2_pending_clr", BASE + 32'h00, 32'h0);
        @(negedge pclk); ext_irq[2] = 1'b0;
        repeat (4) @(negedge pclk); ext_irq[2] = 1'b1;
        repeat (5) @(negedge pclk);
        check("src2_inservice_masks", cpu_irq, 0);
        rd_chk("src2_repend", BASE + 32'h00, 32'h04);
        wr_chk("cmp3", BASE + 32'h0C, 32'h3, 4'hF, 0);
        @(posedge pclk); #1 check("cmp3_reraise", cpu_irq, 1);
        rd_chk("src2_claim2", BASE + 32'h08, 32'h3);
        wr_chk("cmp3b", BASE + 32'h0C, 32'h3, 4'hF, 0);
        ext_irq[2] = 1'b0;

        // Timer beats external source 1
        wr_chk("en_ff", BASE + 32'h04, 32'hFF, 4'hF, 0);
        @(negedge pclk); timer_irq = 1'b1; ext_irq[1] = 1'b1;
        repeat (5) @(negedge pclk);
        check("tmr_cpu_irq", cpu_irq, 1);
        rd_chk("tmr_claim", BASE + 32'h08, 32'h1);
        rd_chk("tmr_pending_held", BASE + 32'h00, 32'h03);
        @(negedge pclk); timer_irq = 1'b0; ext_irq[1] = 1'b0;
        repeat (2) @(negedge pclk);
        wr_chk("cmp1", BASE + 32'h0C, 32'h1, 4'hF, 0);
        rd_chk("src1_claim", BASE + 32'h08, 32'h2);
        rd_chk("after_src1_pending", BASE + 32'h00, 32'h0);
        wr_chk("cmp2", BASE + 32'h0C, 32'h2, 4'hF, 0);

        // Source 3: new edge lands in the same cycle as its claim
        @(negedge pclk); ext_irq[3] = 1'b1;
        repeat (2) @(negedge pclk); ext_irq[3] = 1'b0;
        repeat (4) @(negedge pclk); ext_irq[3] = 1'b1;
        rd_chk("src3_claim", BASE + 32'h08, 32'h4);
        @(posedge pclk); #1 check("src3_claimed_cpu_irq", cpu_irq, 0);
        rd_chk("src3_set_wins", BASE + 32'h00, 32'h08);
        wr_chk("cmp4", BASE + 32'h0C, 32'h4, 4'hF, 0);
        @(posedge pclk); #1 check("cmp4_reraise", cpu_irq, 1);
        ext_irq[3] = 1'b0;
        rd_chk("src3_claim2", BASE + 32'h08, 32'h4);

        // Errors and ignored writes (source 3 still in service)
        bus(1'b0, BASE + 32'h30, 32'h0, 4'h0, rd, err);
        check("off30_perr", err, 1);
        bus(1'b0, 32'h0000_0000, 32'h0, 4'h0, rd, err);
        check("outside_perr", err, 1);
        wr_chk("thresh_absent", BASE + 32'h10, 32'h1, 4'hF, 1);
        wr_chk("cmp9", BASE + 32'h0C, 32'h9, 4'hF, 0);
        rd_chk("cmp9_claim", BASE + 32'h08, 32'h0);
        @(negedge pclk); ext_irq[3] = 1'b1;
        repeat (5) @(negedge pclk);
        check("cmp9_kept_inservice", cpu_irq, 0);
        wr_chk("pending_ro", BASE + 32'h00, 32'hFF, 4'hF, 0);
        rd_chk("pending_ro_rd", BASE + 32'h00, 32'h08);
        wr_chk("cmp4b", BASE + 32'h0C, 32'h4, 4'hF, 0);
        rd_chk("src3_claim3", BASE + 32'h08, 32'h4);
        wr_chk("cmp4c", BASE + 32'h0C, 32'h4, 4'hF, 0);
        ext_irq[3] = 1'b0;

        // Byte strobes, disable/re-enable of a pending source
        wr_chk("en_strb", BASE + 32'h04, 32'h00, 4'hE, 0);
        rd_chk("en_strb_rd", BASE + 32'h04, 32'hFF);
        wr_chk("en_00", BASE + 32'h04, 32'h00, 4'hF, 0);
        @(negedge pclk); ext_irq[5] = 1'b1;
        repeat (5) @(negedge pclk);
        check("disabled_cpu_irq", cpu_irq, 0);
        rd_chk("disabled_pending", BASE + 32'h00, 32'h20);
        wr_chk("reen_ff", BASE + 32'h04, 32'hFF, 4'hF, 0);
        @(posedge pclk); #1 check("reen_cpu_irq", cpu_irq, 1);

        // Reset in the middle of an access with source 5 pending
        @(negedge pclk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = BASE;
        @(negedge pclk); penable = 1'b1;
        @(posedge pclk); #1 check("mid_pready", pready, 1);
        #2 presetn = 1'b0;
        #1 check("rst_mid_pready", pready, 0);
        check("rst_mid_cpu_irq", cpu_irq, 0);
        check("rst_mid_perr", perr, 0);
        @(negedge pclk); psel = 1'b0; penable = 1'b0; ext_irq = '0;
        @(negedge pclk); presetn = 1'b1;
        rd_chk("post_rst_pending", BASE + 32'h00, 32'h0);
        rd_chk("post_rst_enable",  BASE + 32'h04, 32'h0);

        repeat (3) @(negedge pclk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller directly downstream of the machine timer.
- Consumes the timer's level `timer_interrupt` plus external interrupt lines.
- Latches, masks and prioritises them, and drives a single level interrupt to the CPU trap logic.
- Software access is through the same APB-style slave port as the timer, with a claim/complete protocol so the handler can identify and retire sources.

Parameters:
- ADDR_WIDTH, 32, bus address width.
- DATA_WIDTH, 32, bus data width; must be 32.
- NUM_SRC, 8, total sources incl. timer; range 2..31. Source 0 = timer, sources 1..NUM_SRC-1 = external.
- BASE_ADDR, 'h11008000, base of the 64-byte register window.

Ports:
- pclk  in  1  clock.
- presetn  in  1  asynchronous active-low reset.
- paddr  in  ADDR_WIDTH  bus address.
- pdata  in  DATA_WIDTH  write data.
- prdata  out  DATA_WIDTH  read data; valid while pready=1.
- psel  in  1  slave select.
- penable  in  1  access phase.
- pwrite  in  1  1=write.
- pstb  in  4  byte strobes for writes.
- pready  out  1  one-cycle transfer-complete pulse.
- perr  out  1  error, valid with pready.
- timer_irq  in  1  level interrupt from the timer; pclk domain.
- ext_irq  in  NUM_SRC-1  asynchronous external lines, rising-edge sensitive.
- cpu_irq  out  1  level interrupt request to the core.

Behaviour:
- Reset: pready=0, perr=0, prdata=0, cpu_irq=0, pending=0, enable=0, in_service=0, synchronisers=0.
- Bus protocol:
  - Access accepted on the cycle with psel && penable && !pready.
  - pready=1 on the next cycle for exactly one cycle; then 0 even if psel/penable stay high.
  - prdata and perr are registered at acceptance.
  - perr=1 only for offsets outside the map, or ADDR outside the window while psel is high. Otherwise perr=0.
- Register map (offset from BASE_ADDR):
  - 0x00 PENDING (RO): bit i = pending[i]. Writes ignored, no error.
  - 0x04 ENABLE (RW): bits NUM_SRC-1..0. Write honours pstb per byte. Unused bits read 0.
  - 0x08 CLAIM (RO, side effect): returns ID = index+1 of the highest-priority source with pending&enable&~in_service, or 0 if none.
    - On a nonzero read: set in_service[idx]; clear pending[idx] if idx≠0.
  - 0x0C COMPLETE (WO): write ID in pdata[4:0]. If 1..NUM_SRC and in_service set, clear it; otherwise ignore. Reads return 0.
- Timer source (idx 0):
  - pending[0] mirrors timer_irq each cycle (level); never cleared by claim.
  - in_service[0] still gates re-presentation until complete.
- External sources:
  - 2-flop synchroniser, then rising-edge detect.
  - An edge sets pending, held until claimed.
  - Edge and claim-clear in the same cycle: set wins, pending stays 1.
- Priority: lowest index wins; timer highest.
- cpu_irq: registered |(pending & enable & ~in_service); 1-cycle latency from the state change.
- Edge-to-cpu_irq latency for an enabled external source: 4 pclk (2 sync, 1 edge-detect/pending, 1 output).
- Reset asserted mid-transfer: pready drops immediately; the transfer is lost and no side effects are kept.
- Disabling a pending source keeps pending set; re-enabling re-raises cpu_irq.

Optional Feature:
- Macro: IRQ_CTRL_PRIORITY_EN.
- Defined:
  - Registers 0x20+4*i PRIO[i] (3 bits RW, reset 0) and 0x10 THRESHOLD (3 bits RW, reset 0).
  - A source is eligible only if PRIO>THRESHOLD.
  - Claim picks the highest PRIO; ties go to the lowest index.
  - cpu_irq considers only eligible sources.
  - Claim result must be computed in ≤1 cycle.
- Undefined: offsets 0x10 and 0x20+ give perr=1; fixed lowest-index priority.

Decomposition:
- irq_ctrl_pkg: register offset constants, ID width (5), PRIO width (3), ID-0 "none" constant.
- Sub-module irq_sync_edge: 2-flop synchroniser + rising-edge pulse, async active-low reset. One instance per external source.

Test Plan:
- Reset, then read 0x00/0x04/0x08 -> all 0, cpu_irq=0, perr=0.
- Write ENABLE=0x04, pulse ext_irq[2] (src idx 2) -> cpu_irq=1 after 4 cycles. CLAIM reads 3; PENDING bit2 clears; cpu_irq=0 next cycle. COMPLETE 3 -> in_service cleared.
- ENABLE=0xFF, timer_irq=1 and ext_irq[1] edge together -> CLAIM returns 1 (timer), then 2 after complete of ID 1 and the next claim. Pending[0] stays 1 while timer_irq=1.
- Edge on src 3 in the same cycle as its claim -> pending[3] remains 1 and cpu_irq re-asserts after COMPLETE 4.
- Access to BASE_ADDR+0x30 without IRQ_CTRL_PRIORITY_EN -> pready pulse with perr=1. COMPLETE 9 (never claimed) -> no state change.
- Assert presetn low mid-access with pending set -> pready=0, pending=0, cpu_irq=0 immediately.
